// File: rtl/ai_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ai_seq_pkg
// Description : Shared constants for the BattleChip AI sequencer. Holds the
//               sequencer state encoding, the slave address map and a helper
//               that identifies states in which the slave may stall us.
// Revision    : 1.0 - initial release
// ============================================================================
package ai_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_WRITE = 3'd1;
    localparam state_t c_ST_GO    = 3'd2;
    localparam state_t c_ST_GUARD = 3'd3;
    localparam state_t c_ST_POLL  = 3'd4;
    localparam state_t c_ST_READ  = 3'd5;
    localparam state_t c_ST_DONE  = 3'd6;
    localparam state_t c_ST_ERROR = 3'd7;

    // Slave address map: addr 0 is the GO/result register, arguments follow.
    localparam logic [3:0] c_ADDR_GO       = 4'd0;
    localparam logic [3:0] c_ADDR_ARG_BASE = 4'd1;

    // States in which a high wait_request counts towards the stall timeout.
    function automatic logic is_stall_state(input state_t s);
        return (s == c_ST_WRITE) || (s == c_ST_GO) ||
               (s == c_ST_POLL)  || (s == c_ST_READ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ai_sequencer_stall_timer.sv
`default_nettype none
// ============================================================================
// Module      : stall_timer
// Description : Counts consecutive stalled cycles and flags the cycle that
//               completes the TIMEOUT_CYCLES-th consecutive stall.
// Ports       : clock    - clock, posedge
//               reset    - synchronous active-high reset
//               clear    - zero the count (any non-stalled cycle)
//               count_en - this cycle is a stalled cycle
//               expired  - this cycle is the TIMEOUT_CYCLES-th stall in a row
// Revision    : 1.0 - initial release
// ============================================================================
module stall_timer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (count_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // The count holds the number of stalls already seen, so the current
    // stalled cycle is the last allowed one when the count is TIMEOUT-1.
    assign expired = count_en && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ai_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ai_sequencer
// Description : Avalon-MM master driving one run of the AI accelerator slave:
//               writes NUM_ARGS shadow argument words to addr 1..NUM_ARGS,
//               writes GO to addr 0, waits for the slave to finish and reads
//               the result back from addr 0.
// Ports       : clock, reset          - clock / synchronous active-high reset
//               cfg_we/idx/data       - shadow argument write port
//               start                 - launch a sequence (accepted in IDLE)
//               busy, done            - run in progress / end-of-run pulse
//               err_timeout           - sticky stall-timeout abort flag
//               result                - last successfully read slave word
//               ai_*                  - Avalon-MM master towards the slave
// Revision    : 1.0 - initial release
// ============================================================================
module ai_sequencer
    import ai_seq_pkg::*;
#(
    parameter int NUM_ARGS       = 9,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int DATA_W         = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_idx,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        ai_addr,
    output logic              ai_write_en,
    output logic              ai_read_en,
    output logic [DATA_W-1:0] ai_data_in,
    input  logic              ai_wait_request,
    input  logic [DATA_W-1:0] ai_data_out
);

    localparam logic [3:0] c_LAST_IDX = 4'(NUM_ARGS);

    state_t            r_state;
    logic [3:0]        r_idx;
    logic [DATA_W-1:0] r_args [NUM_ARGS];
    logic [DATA_W-1:0] r_result;
    logic              r_err;

    logic              w_cfg_open;
    logic [DATA_W-1:0] w_arg_sel;
    logic              w_count_en;
    logic              w_expired;

    // Arguments are frozen for the whole run so the bus data stays stable.
    assign w_cfg_open = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE) ||
                        (r_state == c_ST_ERROR);

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_ARGS; i++) begin
            if (reset) begin
                r_args[i] <= '0;
            end else if (w_cfg_open && cfg_we && (cfg_idx == 4'(i + 1))) begin
                r_args[i] <= cfg_data;
            end
        end
    end

    always_comb begin
        w_arg_sel = '0;
        for (int i = 0; i < NUM_ARGS; i++) begin
            if (r_idx == 4'(i + 1)) begin
                w_arg_sel = r_args[i];
            end
        end
    end

    // Every non-stalled cycle is either a completion, a poll success or a
    // state without bus activity, so clearing on !count_en covers all cases.
    assign w_count_en = is_stall_state(r_state) && ai_wait_request;

    stall_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (!w_count_en),
        .count_en (w_count_en),
        .expired  (w_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_idx    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_WRITE;
                        r_idx   <= c_ADDR_ARG_BASE;
                        r_err   <= 1'b0;
                    end
                end
                c_ST_WRITE: begin
                    if (w_expired) begin
                        r_state <= c_ST_ERROR;
                        r_err   <= 1'b1;
                    end else if (!ai_wait_request) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_ST_GO;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                c_ST_GO: begin
                    if (w_expired) begin
                        r_state <= c_ST_ERROR;
                        r_err   <= 1'b1;
                    end else if (!ai_wait_request) begin
                        r_state <= c_ST_GUARD;
                    end
                end
                // The slave needs one cycle to raise wait_request after GO;
                // polling before then would see a stale "ready".
                c_ST_GUARD: r_state <= c_ST_POLL;
                c_ST_POLL: begin
                    if (w_expired) begin
                        r_state <= c_ST_ERROR;
                        r_err   <= 1'b1;
                    end else if (!ai_wait_request) begin
                        r_state <= c_ST_READ;
                    end
                end
                c_ST_READ: begin
                    if (w_expired) begin
                        r_state <= c_ST_ERROR;
                        r_err   <= 1'b1;
                    end else if (!ai_wait_request) begin
                        r_state  <= c_ST_DONE;
                        r_result <= ai_data_out;
                    end
                end
                c_ST_DONE:  r_state <= c_ST_IDLE;
                c_ST_ERROR: r_state <= c_ST_IDLE;
                default:    r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Bus signals decode purely from registered state, so they stay stable
    // while stalled and drop on the same edge that enters ERROR.
    always_comb begin
        ai_addr     = c_ADDR_GO;
        ai_write_en = 1'b0;
        ai_read_en  = 1'b0;
        ai_data_in  = '0;
        case (r_state)
            c_ST_WRITE: begin
                ai_addr     = r_idx;
                ai_write_en = 1'b1;
                ai_data_in  = w_arg_sel;
            end
            c_ST_GO:   ai_write_en = 1'b1;
            c_ST_READ: ai_read_en  = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (r_state == c_ST_WRITE) || (r_state == c_ST_GO) ||
                         (r_state == c_ST_GUARD) || (r_state == c_ST_POLL) ||
                         (r_state == c_ST_READ);
    assign done        = (r_state == c_ST_DONE) || (r_state == c_ST_ERROR);
    assign err_timeout = r_err;
    assign result      = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ai_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ai_sequencer
// Description : Self-checking bench for ai_sequencer with a behavioural AI
//               slave (argument registers, compute delay, programmable write
//               stall) and a reference for write order, timing and result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ai_sequencer;

    localparam int NA = 9;
    localparam int TO = 16;
    localparam int DW = 32;
    localparam int BASE_LAT = NA + 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_idx = '0;
    logic [DW-1:0] cfg_data = '0;
    logic          start = 1'b0;
    logic          busy, done, err_timeout;
    logic [DW-1:0] result;
    logic [3:0]    ai_addr;
    logic          ai_write_en, ai_read_en;
    logic [DW-1:0] ai_data_in;
    logic          ai_wait_request;
    logic [DW-1:0] ai_data_out;

    always #5 clock = ~clock;

    ai_sequencer #(
        .NUM_ARGS       (NA),
        .TIMEOUT_CYCLES (TO),
        .DATA_W         (DW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .cfg_we          (cfg_we),
        .cfg_idx         (cfg_idx),
        .cfg_data        (cfg_data),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .err_timeout     (err_timeout),
        .result          (result),
        .ai_addr         (ai_addr),
        .ai_write_en     (ai_write_en),
        .ai_read_en      (ai_read_en),
        .ai_data_in      (ai_data_in),
        .ai_wait_request (ai_wait_request),
        .ai_data_out     (ai_data_out)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    logic [DW-1:0] m_args [1:NA];
    logic [DW-1:0] last_res;

    // Slave model controls
    int   compute    = 0;
    int   stall_addr = 0;
    int   stall_n    = 0;
    logic sl_clr     = 1'b1;

    // Slave model state
    logic [DW-1:0] s_mem [0:15];
    int            s_comp    = 0;
    int            s_stalled = 0;
    logic [3:0]    wlog_a [$];
    logic [DW-1:0] wlog_d [$];

    function automatic logic [DW-1:0] model_word(input logic [DW-1:0] a [1:NA]);
        logic [DW-1:0] t;
        t = 32'h1357_9BDF;
        for (int i = 1; i <= NA; i++) t = {t[26:0], t[31:27]} ^ a[i];
        return t;
    endfunction

    always_comb begin
        logic [DW-1:0] t;
        t = 32'h1357_9BDF;
        for (int i = 1; i <= NA; i++) t = {t[26:0], t[31:27]} ^ s_mem[i];
        ai_data_out = t;
    end

    always_comb begin
        ai_wait_request = 1'b0;
        if (s_comp != 0) ai_wait_request = 1'b1;
        if (ai_write_en && (ai_addr == 4'(stall_addr)) && (s_stalled < stall_n))
            ai_wait_request = 1'b1;
    end

    always @(posedge clock) begin
        if (sl_clr) begin
            s_comp    <= 0;
            s_stalled <= 0;
            for (int i = 0; i < 16; i++) s_mem[i] <= '0;
        end else begin
            if (s_comp != 0) s_comp <= s_comp - 1;
            if (ai_write_en && !ai_wait_request) begin
                s_mem[ai_addr] <= ai_data_in;
                wlog_a.push_back(ai_addr);
                wlog_d.push_back(ai_data_in);
                // busy through the GUARD cycle plus 'compute' poll cycles
                if (ai_addr == 4'd0) s_comp <= compute + 1;
            end else if (ai_write_en && ai_wait_request && (ai_addr == 4'(stall_addr))) begin
                s_stalled <= s_stalled + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [DW-1:0] d);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_data = d;
        @(negedge clock);
        cfg_we = 1'b0;
        if (idx >= 4'd1 && idx <= 4'(NA)) m_args[idx] = d;
    endtask

    task automatic set_slave(input int comp, input int saddr, input int sn);
        compute    = comp;
        stall_addr = saddr;
        stall_n    = sn;
        sl_clr     = 1'b1;
        @(negedge clock);
        sl_clr = 1'b0;
    endtask

    // Called at a negedge; start is sampled at the following edge (edge 0).
    task automatic run_seq(input string tag, input int inj_cyc, input int rst_cyc,
                           input int exp_done, input logic exp_err);
        int            base, done_k;
        logic [DW-1:0] exp_res;
        logic          p_stall;
        logic [3:0]    p_addr;
        logic          p_we, p_re;
        logic [DW-1:0] p_din;
        base    = wlog_a.size();
        done_k  = 0;
        p_stall = 1'b0;
        p_addr  = '0; p_we = 1'b0; p_re = 1'b0; p_din = '0;
        exp_res = exp_err ? last_res : model_word(m_args);
        start   = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
        cfg_we = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (p_stall) begin
                check({tag, " held addr"},  ai_addr,     p_addr);
                check({tag, " held data"},  ai_data_in,  p_din);
                check({tag, " held we"},    ai_write_en, p_we);
                check({tag, " held re"},    ai_read_en,  p_re);
            end
            if (k == 1) begin
                check({tag, " busy@1"}, busy, 1'b1);
                check({tag, " err@1"},  err_timeout, 1'b0);
            end
            if (rst_cyc != 0 && k == rst_cyc + 1) begin
                check({tag, " rst busy"},  busy, 1'b0);
                check({tag, " rst done"},  done, 1'b0);
                check({tag, " rst we"},    ai_write_en, 1'b0);
                check({tag, " rst addr"},  ai_addr, 4'd0);
                check({tag, " rst din"},   ai_data_in, 32'd0);
                check({tag, " rst res"},   result, 32'd0);
                reset = 1'b0;
                repeat (5) begin
                    @(negedge clock);
                    check({tag, " no done"}, done, 1'b0);
                end
                last_res = '0;
                return;
            end
            if (rst_cyc != 0 && k == rst_cyc) begin
                check({tag, " addr before rst"}, ai_addr, 4'(rst_cyc));
                reset = 1'b1;
            end
            if (done) begin
                done_k = k;
                break;
            end
            if (k == inj_cyc) begin
                start = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd3; cfg_data = 32'hABCD;
            end
            if (k == inj_cyc + 1) begin
                start = 1'b0; cfg_we = 1'b0;
            end
            p_stall = (ai_write_en || ai_read_en) && ai_wait_request;
            p_addr  = ai_addr; p_we = ai_write_en; p_re = ai_read_en; p_din = ai_data_in;
        end
        check({tag, " done cycle"}, done_k, exp_done);
        check({tag, " err"},        err_timeout, exp_err);
        check({tag, " busy@done"},  busy, 1'b0);
        check({tag, " result"},     result, exp_res);
        check({tag, " we@done"},    ai_write_en, 1'b0);
        check({tag, " re@done"},    ai_read_en, 1'b0);
        check({tag, " nwrites"},    wlog_a.size() - base, NA + 1);
        if (wlog_a.size() - base == NA + 1) begin
            for (int j = 0; j <= NA; j++) begin
                check({tag, " wr addr"}, wlog_a[base + j], (j < NA) ? 4'(j + 1) : 4'd0);
                check({tag, " wr data"}, wlog_d[base + j], (j < NA) ? m_args[j + 1] : 32'd0);
            end
        end
        if (!exp_err) last_res = exp_res;
        @(negedge clock);
        check({tag, " done pulse"}, done, 1'b0);
        check({tag, " idle busy"},  busy, 1'b0);
    endtask

    initial begin
        for (int i = 1; i <= NA; i++) m_args[i] = '0;
        last_res = '0;
        repeat (3) @(negedge clock);
        check("reset busy",   busy, 1'b0);
        check("reset done",   done, 1'b0);
        check("reset err",    err_timeout, 1'b0);
        check("reset result", result, 32'd0);
        check("reset addr",   ai_addr, 4'd0);
        check("reset we",     ai_write_en, 1'b0);
        check("reset re",     ai_read_en, 1'b0);
        check("reset din",    ai_data_in, 32'd0);
        reset  = 1'b0;
        sl_clr = 1'b0;
        @(negedge clock);

        // Basic run: args 1..8 = 0, arg9 = 31, 3-cycle compute
        cfg_write(4'd9, 32'd31);
        set_slave(3, 0, 0);
        run_seq("s1", 0, 0, BASE_LAT + 3, 1'b0);

        // Three stall cycles on the addr 5 write
        set_slave(3, 5, 3);
        run_seq("s2", 0, 0, BASE_LAT + 6, 1'b0);

        // Random arguments, compute time and write stalls
        for (int r = 0; r < 4; r++) begin
            int c, sa, sn;
            for (int i = 1; i <= NA; i++) cfg_write(4'(i), $urandom());
            c  = int'($urandom_range(0, 5));
            sa = int'($urandom_range(1, NA));
            sn = int'($urandom_range(0, 4));
            set_slave(c, sa, sn);
            run_seq("rnd", 0, 0, BASE_LAT + c + sn, 1'b0);
        end

        // Slave never finishes: abort after TO stalled POLL cycles
        set_slave(1000, 0, 0);
        run_seq("s3", 0, 0, NA + 3 + TO, 1'b1);
        repeat (3) @(negedge clock);
        check("s3 err sticky", err_timeout, 1'b1);
        check("s3 idle done",  done, 1'b0);

        // start + cfg_we mid-run are ignored; new start clears err_timeout
        set_slave(0, 0, 0);
        run_seq("s4", 4, 0, BASE_LAT, 1'b0);
        run_seq("s4b", 0, 0, BASE_LAT, 1'b0);

        // Reset while writing addr 4, then a fresh run with zeroed args
        run_seq("s5", 0, 4, 0, 1'b0);
        for (int i = 1; i <= NA; i++) m_args[i] = '0;
        set_slave(0, 0, 0);
        run_seq("s5b", 0, 0, BASE_LAT, 1'b0);

        // Out-of-range indices ignored; cfg_we with start uses the new value
        cfg_write(4'd0,  32'hDEAD_0000);
        cfg_write(4'd12, 32'hBEEF_0000);
        cfg_we   = 1'b1;
        cfg_idx  = 4'd9;
        cfg_data = 32'd7;
        m_args[9] = 32'd7;
        set_slave(2, 0, 0);
        cfg_we   = 1'b1;
        run_seq("s6", 0, 0, BASE_LAT + 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
